// File: rtl/axi_dma_burst_splitter.sv
// Splits one DMA command into AXI-legal burst requests, capping each burst by
// MAX_BURST_LEN, the 4 KB boundary on both source and destination, and burst type.
module axi_dma_burst_splitter #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WD        = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  input  logic [ADDR_WD-1:0] cmd_src_addr_i,
  input  logic [ADDR_WD-1:0] cmd_dst_addr_i,
  input  logic [1:0]         cmd_burst_i,
  input  logic [LEN_WD-1:0]  cmd_len_i,
  input  logic [2:0]         cmd_size_i,
  output logic               cmd_ready_o,
  output logic               cmd_err_o,
  output logic               req_valid_o,
  output logic [ADDR_WD-1:0] req_src_addr_o,
  output logic [ADDR_WD-1:0] req_dst_addr_o,
  output logic [7:0]         req_len_o,
  output logic [2:0]         req_size_o,
  output logic [1:0]         req_burst_o,
  output logic               req_last_o,
  input  logic               req_ready_i
);

  localparam int MAX_SIZE = $clog2(DATA_WD / 8);
  localparam int N_WD     = LEN_WD + 1;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] src_q, src_d;
  logic [ADDR_WD-1:0] dst_q, dst_d;
  logic [LEN_WD-1:0]  rem_q, rem_d;
  logic [2:0]         size_q, size_d;
  logic [1:0]         burst_q, burst_d;
  logic               err_q, err_d;

  function automatic logic [N_WD-1:0] minOf(input logic [N_WD-1:0] a, input logic [N_WD-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Legality of the command presented on the handshake cycle.
  logic [ADDR_WD-1:0] alignMask;
  logic               misaligned;
  logic               wrapLenOk;
  logic               cmdIllegal;

  always_comb begin
    alignMask  = (ADDR_WD'(1) << cmd_size_i) - ADDR_WD'(1);
    misaligned = ((cmd_src_addr_i & alignMask) != '0) || ((cmd_dst_addr_i & alignMask) != '0);
    wrapLenOk  = ((cmd_len_i == LEN_WD'(2)) || (cmd_len_i == LEN_WD'(4)) ||
                  (cmd_len_i == LEN_WD'(8)) || (cmd_len_i == LEN_WD'(16))) &&
                 (cmd_len_i <= LEN_WD'(MAX_BURST_LEN));
    cmdIllegal = (cmd_len_i == '0) ||
                 (cmd_size_i > 3'(MAX_SIZE)) ||
                 (cmd_burst_i == BURST_RSVD) ||
                 ((cmd_burst_i != BURST_FIXED) && misaligned) ||
                 ((cmd_burst_i == BURST_WRAP) && !wrapLenOk);
  end

  // Beat count of the current burst, derived purely from registered state.
  logic [12:0]     srcDist, dstDist;
  logic [N_WD-1:0] srcBeats, dstBeats, remExt, beats;
  logic            lastBurst;

  always_comb begin
    srcDist  = 13'd4096 - {1'b0, src_q[11:0]};
    dstDist  = 13'd4096 - {1'b0, dst_q[11:0]};
    srcBeats = N_WD'(srcDist >> size_q);
    dstBeats = N_WD'(dstDist >> size_q);
    remExt   = {1'b0, rem_q};
    beats    = remExt;
    case (burst_q)
      BURST_INCR:  beats = minOf(minOf(remExt, N_WD'(MAX_BURST_LEN)), minOf(srcBeats, dstBeats));
      BURST_FIXED: beats = minOf(minOf(remExt, N_WD'(MAX_BURST_LEN)), N_WD'(16));
      default:     beats = remExt;
    endcase
    lastBurst = (beats == remExt);
  end

  // Outputs are forced quiet while reset is held so nothing leaks mid-reset.
  logic emitting;

  always_comb begin
    emitting       = (state_q == EMIT) && !rst_i;
    cmd_ready_o    = (state_q == IDLE) && !rst_i;
    cmd_err_o      = err_q;
    req_valid_o    = emitting;
    req_src_addr_o = emitting ? src_q : '0;
    req_dst_addr_o = emitting ? dst_q : '0;
    req_len_o      = emitting ? 8'(beats - N_WD'(1)) : 8'd0;
    req_size_o     = emitting ? size_q : 3'd0;
    req_burst_o    = emitting ? burst_q : 2'd0;
    req_last_o     = emitting && lastBurst;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmdIllegal) begin
            err_d = 1'b1;
          end else begin
            src_d   = cmd_src_addr_i;
            dst_d   = cmd_dst_addr_i;
            rem_d   = cmd_len_i;
            size_d  = cmd_size_i;
            burst_d = cmd_burst_i;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (req_ready_i) begin
          rem_d = rem_q - beats[LEN_WD-1:0];
          if (burst_q == BURST_INCR) begin
            src_d = src_q + (ADDR_WD'(beats) << size_q);
            dst_d = dst_q + (ADDR_WD'(beats) << size_q);
          end
          if (lastBurst) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

endmodule
